// File: rtl/key_conditioner.sv
// Two-button key conditioner: synchronizes and debounces raw buttons, then turns
// presses into single-cycle up/down pulses with hold-to-repeat behaviour.
module key_conditioner #(
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_BITS      = 26
) (
    input  logic Clock,
    input  logic resetn,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic enable,
    output logic out_up,
    output logic out_dn,
    output logic held
);

    localparam logic [CNT_BITS-1:0] DEB_LAST  = CNT_BITS'(DEB_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(HOLD_DELAY - 1);
    localparam logic [CNT_BITS-1:0] REP_LAST  = CNT_BITS'(REPEAT_PERIOD - 1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_MAX   = {CNT_BITS{1'b1}};

    typedef enum logic [1:0] {IDLE, PRESS, REPEAT, LOCK} state_t;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] value);
        sat_inc = (value == CNT_MAX) ? value : value + CNT_BITS'(1);
    endfunction

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]                 raw_s;
    logic [1:0]                 sync1_r;
    logic [1:0]                 sync2_r;
    logic [1:0]                 deb_r;
    logic [1:0][CNT_BITS-1:0]   deb_cnt_r;
    state_t                     state_r;
    logic                       dir_r;
    logic [CNT_BITS-1:0]        hold_r;
    logic                       latched_s;
    logic                       opposite_s;
    logic [CNT_BITS-1:0]        step_last_s;

    assign raw_s       = {btn_dn, btn_up};
    assign latched_s   = dir_r ? deb_r[1] : deb_r[0];
    assign opposite_s  = dir_r ? deb_r[0] : deb_r[1];
    assign step_last_s = (state_r == PRESS) ? HOLD_LAST : REP_LAST;

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge Clock or posedge resetn) begin
        if (resetn) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debouncer: level flips after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge Clock or posedge resetn) begin
        if (resetn) begin
            deb_r     <= 2'b00;
            deb_cnt_r <= {2{CNT_ZERO}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= CNT_ZERO;
                end else if (deb_cnt_r[i] >= DEB_LAST) begin
                    deb_r[i]     <= ~deb_r[i];
                    deb_cnt_r[i] <= CNT_ZERO;
                end else begin
                    deb_cnt_r[i] <= sat_inc(deb_cnt_r[i]);
                end
            end
        end
    end

    // Press / repeat / lock state machine with registered pulse outputs.
    always_ff @(posedge Clock or posedge resetn) begin
        if (resetn) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            hold_r  <= CNT_ZERO;
            out_up  <= 1'b0;
            out_dn  <= 1'b0;
            held    <= 1'b0;
        end else if (!enable) begin
            state_r <= IDLE;
            hold_r  <= CNT_ZERO;
            out_up  <= 1'b0;
            out_dn  <= 1'b0;
            held    <= 1'b0;
        end else begin
            out_up <= 1'b0;
            out_dn <= 1'b0;
            case (state_r)
                IDLE: begin
                    held   <= 1'b0;
                    hold_r <= CNT_ZERO;
                    if (deb_r == 2'b11) begin
                        state_r <= LOCK;
                    end else if (deb_r != 2'b00) begin
                        state_r <= PRESS;
                        dir_r   <= deb_r[1];
                        out_up  <= deb_r[0];
                        out_dn  <= deb_r[1];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESS, REPEAT: begin
                    if (!latched_s) begin
                        state_r <= IDLE;
                        held    <= 1'b0;
                        hold_r  <= CNT_ZERO;
                    end else if (opposite_s) begin
                        state_r <= LOCK;
                        held    <= 1'b0;
                        hold_r  <= CNT_ZERO;
                    end else if (hold_r >= step_last_s) begin
                        state_r <= REPEAT;
                        held    <= 1'b1;
                        hold_r  <= CNT_ZERO;
                        out_up  <= ~dir_r;
                        out_dn  <= dir_r;
                    end else begin
                        held    <= (state_r == REPEAT);
                        hold_r  <= sat_inc(hold_r);
                    end
                end
                LOCK: begin
                    held   <= 1'b0;
                    hold_r <= CNT_ZERO;
                    if (deb_r == 2'b00) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    held    <= 1'b0;
                    hold_r  <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random button activity,
// compared every cycle against an event-level reference model.
module tb_key_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic Clock;
    logic resetn;
    logic btn_up;
    logic btn_dn;
    logic enable;
    logic out_up;
    logic out_dn;
    logic held;

    int n_checks = 0;
    int n_pass   = 0;

    key_conditioner #(
        .DEB_CYCLES   (DEB),
        .HOLD_DELAY   (HOLD),
        .REPEAT_PERIOD(REP),
        .CNT_BITS     (8)
    ) dut (
        .Clock (Clock),
        .resetn(resetn),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .enable(enable),
        .out_up(out_up),
        .out_dn(out_dn),
        .held  (held)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model state: raw sample history, debounced levels, press bookkeeping.
    logic [1:0] hist[$];
    logic [1:0] m_deb;
    int         m_mode;      // 0 idle, 1 pressed (one key), 2 locked
    int         m_dir;       // 0 up, 1 down
    int         m_el;        // edges since the first pulse of this press
    logic       m_up, m_dn, m_held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        m_deb  = 2'b00;
        m_mode = 0;
        m_dir  = 0;
        m_el   = 0;
        m_up   = 1'b0;
        m_dn   = 1'b0;
        m_held = 1'b0;
    endtask

    // Synchronized value the debouncer sees, 'back' edges ago; before reset history it is 0.
    function automatic logic [1:0] seen_at(input int back);
        int idx;
        idx = hist.size() - 3 - back;
        if (idx < 0) return 2'b00;
        return hist[idx];
    endfunction

    task automatic model_edge();
        logic [1:0] d;
        logic [1:0] s;
        logic       flip;
        d    = m_deb;
        m_up = 1'b0;
        m_dn = 1'b0;
        if (!enable) begin
            m_mode = 0;
            m_held = 1'b0;
        end else if (m_mode == 0) begin
            m_held = 1'b0;
            if (d == 2'b11) m_mode = 2;
            else if (d != 2'b00) begin
                m_mode = 1;
                m_dir  = d[1] ? 1 : 0;
                m_el   = 0;
                m_up   = d[0];
                m_dn   = d[1];
            end
        end else if (m_mode == 1) begin
            if (!d[m_dir]) begin
                m_mode = 0;
                m_held = 1'b0;
            end else if (d[1 - m_dir]) begin
                m_mode = 2;
                m_held = 1'b0;
            end else begin
                m_el++;
                if (m_el >= HOLD && ((m_el - HOLD) % REP) == 0) begin
                    m_up = (m_dir == 0);
                    m_dn = (m_dir == 1);
                end
                m_held = (m_el >= HOLD);
            end
        end else begin
            m_held = 1'b0;
            if (d == 2'b00) m_mode = 0;
        end
        // A debounced level flips once its last DEB synchronized samples all disagree with it.
        hist.push_back({btn_dn, btn_up});
        if (hist.size() > 64) void'(hist.pop_front());
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                s = seen_at(j);
                if (s[b] == m_deb[b]) flip = 1'b0;
            end
            if (flip) m_deb[b] = ~m_deb[b];
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".out_up"}, {31'd0, out_up}, {31'd0, m_up});
        check({tag, ".out_dn"}, {31'd0, out_dn}, {31'd0, m_dn});
        check({tag, ".held"},   {31'd0, held},   {31'd0, m_held});
        check({tag, ".excl"},   {31'd0, out_up & out_dn}, 32'd0);
    endtask

    task automatic step(input string tag);
        @(posedge Clock);
        if (resetn) model_reset();
        else model_edge();
        #1;
        compare_outputs(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Steps n edges and reports the 1-based edge after which out_up first went high (0 = never).
    task automatic run_find(input string tag, input int n, output int first);
        first = 0;
        for (int i = 1; i <= n; i++) begin
            step(tag);
            if (out_up && first == 0) first = i;
        end
    endtask

    task automatic async_reset(input string tag, input int hold_cycles);
        resetn = 1'b1;
        #2;
        model_reset();
        compare_outputs({tag, ".async"});
        steps(tag, hold_cycles);
        resetn = 1'b0;
    endtask

    int first;
    int bounce_first;
    int gl[6] = '{2, 1, 3, 2, 1, 3};
    int run_up, run_dn;

    initial begin
        resetn = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        enable = 1'b1;
        model_reset();
        steps("reset", 3);
        resetn = 1'b0;
        steps("idle", 4);

        btn_up = 1'b1;
        run_find("clean", 8, first);
        check("clean.latency", first, DEB + 3);
        btn_up = 1'b0;
        steps("clean", 12);

        btn_dn = 1'b1;
        steps("hold_dn", 40);
        btn_dn = 1'b0;
        steps("hold_dn", 12);

        bounce_first = 0;
        for (int g = 0; g < 6; g++) begin
            btn_up = (g % 2 == 0);
            run_find("bounce", gl[g], first);
            if (first != 0 && bounce_first == 0) bounce_first = first;
        end
        check("bounce.quiet", bounce_first, 0);
        btn_up = 1'b1;
        run_find("bounce", 12, first);
        check("bounce.latency", first, DEB + 3);
        btn_up = 1'b0;
        steps("bounce", 12);

        btn_up = 1'b1;
        steps("lock", 20);
        btn_dn = 1'b1;
        steps("lock", 10);
        btn_up = 1'b0;
        steps("lock", 8);
        btn_dn = 1'b0;
        steps("lock", 12);

        btn_up = 1'b1;
        steps("rst_mid", 20);
        async_reset("rst_mid", 2);
        run_find("rst_mid", 10, first);
        check("rst_mid.latency", first, DEB + 3);
        btn_up = 1'b0;
        steps("rst_mid", 12);

        btn_up = 1'b1;
        steps("enable", 20);
        enable = 1'b0;
        steps("enable", 6);
        enable = 1'b1;
        step("enable");
        check("enable.repulse", {31'd0, out_up}, 32'd1);
        steps("enable", 15);
        btn_up = 1'b0;
        steps("enable", 12);

        run_up = 0;
        run_dn = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_up == 0) begin
                btn_up = $urandom_range(0, 1);
                run_up = $urandom_range(1, 30);
            end
            if (run_dn == 0) begin
                btn_dn = ($urandom_range(0, 3) == 0);
                run_dn = $urandom_range(1, 30);
            end
            run_up--;
            run_dn--;
            if ($urandom_range(0, 199) == 0) enable = 1'b0;
            else if ($urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 999) == 0) async_reset("random", $urandom_range(1, 3));
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, meaning consecutive stable cycles required before a debounced level changes (>=1).
REQ-002 SHALL have parameter HOLD_DELAY, default 25000000, meaning cycles from the first pulse to the first auto-repeat pulse (>=2).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, meaning cycles between auto-repeat pulses (>=1).
REQ-004 SHALL have parameter CNT_BITS, default 26, meaning width of the debounce and hold timers; it must hold max(DEB_CYCLES, HOLD_DELAY, REPEAT_PERIOD).
REQ-005 SHALL have port Clock  input  1  system clock, all state changes on its rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port btn_up  input  1  raw, asynchronous, bouncing "increment" button, active-high.
REQ-008 SHALL have port btn_dn  input  1  raw, asynchronous, bouncing "decrement" button, active-high.
REQ-009 SHALL have port enable  input  1  synchronous pulse-generation enable.
REQ-010 SHALL have port out_up  output  1  single-cycle increment pulse that drives the downstream counter's in1.
REQ-011 SHALL have port out_dn  output  1  single-cycle decrement pulse that drives the downstream counter's in2.
REQ-012 SHALL have port held  output  1  high while in auto-repeat.

Function
REQ-013 SHALL pass each raw button through a private 2-flop synchronizer before any other use.
REQ-014 SHALL run a per-button debouncer: a timer counts cycles where the synchronized level differs from the debounced level, and clears to 0 on any cycle where they match.
REQ-015 SHALL flip the debounced level on the edge where that timer reaches DEB_CYCLES; glitches shorter than DEB_CYCLES cycles SHALL be filtered out.
REQ-016 SHALL implement an FSM with states IDLE, PRESS, REPEAT and LOCK, with registered outputs only.
REQ-017 IDLE: exactly one debounced button pressed -> PRESS, latch direction, assert the matching out_* for one cycle, clear the hold timer.
REQ-018 IDLE: both buttons pressed -> LOCK with no pulse.
REQ-019 PRESS: the hold timer increments each cycle; at HOLD_DELAY-1 -> REPEAT, emit a pulse, clear the timer; the second pulse therefore comes exactly HOLD_DELAY cycles after the first.
REQ-020 REPEAT: emit a pulse every REPEAT_PERIOD cycles, counted from the entry pulse; held=1 in REPEAT only.
REQ-021 PRESS/REPEAT: release of the latched button -> IDLE, no pulse, held=0 on the next edge.
REQ-022 PRESS/REPEAT: the opposite button also pressed -> LOCK, no further pulses.
REQ-023 LOCK: no pulses; -> IDLE only when both debounced levels are 0.
REQ-024 out_up and out_dn SHALL never be high in the same cycle, and each pulse SHALL be exactly 1 cycle wide.
REQ-025 enable=0 SHALL synchronously force the FSM to IDLE, clear the hold timer and zero all outputs; the debouncers keep running.
REQ-026 When enable rises while one button is held, IDLE treats the press as new and pulses.
REQ-027 Latency: raw rise sampled at edge 1 -> out_* high after edge DEB_CYCLES+3 (2 sync + DEB_CYCLES debounce + 1 FSM register).
REQ-028 Timers SHALL saturate, never wrap; all counter widths are CNT_BITS, unsigned.

Reset
REQ-029 resetn=1 SHALL asynchronously clear the synchronizers, the debounced levels and all timers, set the FSM to IDLE, and set out_up=out_dn=held=0.
REQ-030 resetn asserted mid-repeat SHALL suppress any pending pulse; after release a still-held button requires a full DEB_CYCLES debounce before its first pulse.

Verification (DEB_CYCLES=4, HOLD_DELAY=10, REPEAT_PERIOD=3)
REQ-031 btn_up clean press at edge 1, released after 8 cycles -> out_up single pulse after edge 7, out_dn=0, held=0 throughout.
REQ-032 btn_dn held 40 cycles -> out_dn pulses at t, t+10, t+13, t+16, ...; held=1 from t+10 until 1 cycle after debounced release.
REQ-033 btn_up bounce 1-3-cycle glitches, then stable -> no pulse during bounce; exactly one pulse DEB_CYCLES+3 edges after the last transition.
REQ-034 btn_up held into REPEAT, then btn_dn pressed -> pulses stop and the FSM stays in LOCK until both are released; no out_dn pulse.
REQ-035 resetn pulsed mid-REPEAT with btn_up still held -> outputs 0 immediately; next out_up exactly DEB_CYCLES+3 edges after reset release.
REQ-036 enable=0 while btn_up is held -> no pulses; enable returns to 1 -> one pulse the next edge, then repeat timing restarts.
